spike_volley_encoder: RTL and testbench

- Temporal (latency-code) transmitter feeding the winner-take-all lateral inhibition stage.
- Accepts one spike time per input line, then runs one gamma cycle of `time_period steps. It drives `time_val` and a one-hot-per-line `spike_volley`, so each line fires exactly once at its programmed step, or never.
- Brackets each gamma cycle with start/done pulses. Downstream inhibition/winner state clears on `cycle_done`.

---
 rtl/spike_volley_encoder.sv | 112 +++++++++++
 tb/tb_spike_volley_encoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spike_volley_encoder.sv
// Latency-code spike transmitter: latches one spike time per line and replays
// them as a one-hot-per-line volley over a single gamma cycle.
module spike_volley_encoder #(
    parameter int NEURONS     = 8,
    parameter int TIME_PERIOD = 8,
    parameter int TW          = $clog2(TIME_PERIOD) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NEURONS*TW-1:0] spike_times_in,
    input  logic                  clear,
    output logic                  ready,
    output logic                  busy,
    output logic [TW-1:0]         time_val,
    output logic [NEURONS-1:0]    spike_volley,
    output logic                  cycle_start,
    output logic                  cycle_done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [TW-1:0] LAST_STEP = TW'(TIME_PERIOD - 1);
    localparam logic [TW-1:0] NO_SPIKE  = TW'(TIME_PERIOD);

    state_t                state;
    state_t                state_next;
    logic [NEURONS*TW-1:0] lat;
    logic [NEURONS*TW-1:0] lat_next;
    logic [TW-1:0]         time_next;
    logic [TW-1:0]         step_next;
    logic [NEURONS-1:0]    volley_next;
    logic                  start_next;
    logic                  done_next;

    assign ready = (state == IDLE) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat          <= {NEURONS{NO_SPIKE}};
            time_val     <= '0;
            spike_volley <= '0;
            cycle_start  <= 1'b0;
            cycle_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            lat          <= lat_next;
            time_val     <= time_next;
            spike_volley <= volley_next;
            cycle_start  <= start_next;
            cycle_done   <= done_next;
            busy         <= (state_next != IDLE);
        end
    end

    // Volley bits are computed one step ahead so each line lights exactly on its step.
    always_comb begin
        state_next  = state;
        lat_next    = lat;
        time_next   = time_val;
        volley_next = '0;
        start_next  = 1'b0;
        done_next   = 1'b0;
        step_next   = time_val + TW'(1);

        if (clear) begin
            state_next = IDLE;
            time_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    time_next = '0;
                    if (start) begin
                        lat_next   = spike_times_in;
                        state_next = RUN;
                        start_next = 1'b1;
                        for (int i = 0; i < NEURONS; i++) begin
                            volley_next[i] = (spike_times_in[i*TW +: TW] == '0);
                        end
                    end
                end
                RUN: begin
                    if (time_val == LAST_STEP) begin
                        state_next = DONE;
                        time_next  = NO_SPIKE;
                        done_next  = 1'b1;
                    end else begin
                        time_next = step_next;
                        for (int i = 0; i < NEURONS; i++) begin
                            volley_next[i] = (lat[i*TW +: TW] == step_next);
                        end
                    end
                end
                DONE: begin
                    state_next = IDLE;
                    time_next  = '0;
                end
                default: begin
                    state_next = IDLE;
                    time_next  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_volley_encoder.sv
// Scoreboard bench for spike_volley_encoder: a gamma-cycle model queues the
// expected per-cycle outputs, a negedge monitor pops and compares them.
module tb_spike_volley_encoder;

    localparam int N  = 4;
    localparam int TP = 8;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [N*TW-1:0] spike_times_in;
    logic            clear;
    logic            ready;
    logic            busy;
    logic [TW-1:0]   time_val;
    logic [N-1:0]    spike_volley;
    logic            cycle_start;
    logic            cycle_done;

    typedef struct {
        int           t;
        logic [N-1:0] v;
        logic         cs;
        logic         cd;
    } exp_t;

    exp_t q[$];
    int   remaining = 0;
    int   compared  = 0;
    int   mismatched = 0;

    spike_volley_encoder #(.NEURONS(N), .TIME_PERIOD(TP), .TW(TW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .spike_times_in (spike_times_in),
        .clear          (clear),
        .ready          (ready),
        .busy           (busy),
        .time_val       (time_val),
        .spike_volley   (spike_volley),
        .cycle_start    (cycle_start),
        .cycle_done     (cycle_done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*TW-1:0] pack4(input int t0, input int t1, input int t2, input int t3);
        logic [N*TW-1:0] p;
        p[0*TW +: TW] = TW'(t0);
        p[1*TW +: TW] = TW'(t1);
        p[2*TW +: TW] = TW'(t2);
        p[3*TW +: TW] = TW'(t3);
        return p;
    endfunction

    function automatic logic [N*TW-1:0] rand_times();
        logic [N*TW-1:0] p;
        for (int i = 0; i < N; i++) p[i*TW +: TW] = TW'($urandom_range(0, 15));
        return p;
    endfunction

    // A whole gamma cycle is predicted at acceptance: line i fires at step == its time.
    task automatic push_cycle(input logic [N*TW-1:0] times);
        exp_t e;
        for (int t = 0; t < TP; t++) begin
            e.t  = t;
            e.cs = (t == 0);
            e.cd = 1'b0;
            for (int i = 0; i < N; i++) e.v[i] = (int'(times[i*TW +: TW]) == t);
            q.push_back(e);
        end
        e.t  = TP;
        e.v  = '0;
        e.cs = 1'b0;
        e.cd = 1'b1;
        q.push_back(e);
    endtask

    task automatic model_edge();
        if (!rst_n || clear) begin
            remaining = 0;
            q.delete();
        end else if (remaining == 0 && start) begin
            push_cycle(spike_times_in);
            remaining = TP + 1;
        end else if (remaining > 0) begin
            remaining--;
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic c, input logic [N*TW-1:0] times);
        start          = s;
        clear          = c;
        spike_times_in = times;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0 || busy) begin
                if (q.size() == 0) begin
                    check_output("unexpected_busy", 32'(busy), 32'd0);
                end else begin
                    e = q.pop_front();
                    check_output("busy", 32'(busy), 32'd1);
                    check_output("ready_busy", 32'(ready), 32'd0);
                    check_output("time_val", 32'(time_val), 32'(e.t));
                    check_output("spike_volley", 32'(spike_volley), 32'(e.v));
                    check_output("cycle_start", 32'(cycle_start), 32'(e.cs));
                    check_output("cycle_done", 32'(cycle_done), 32'(e.cd));
                end
            end else begin
                check_output("idle_time_val", 32'(time_val), 32'd0);
                check_output("idle_volley", 32'(spike_volley), 32'd0);
                check_output("idle_cycle_start", 32'(cycle_start), 32'd0);
                check_output("idle_cycle_done", 32'(cycle_done), 32'd0);
                check_output("idle_ready", 32'(ready), 32'(!clear));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        rst_n          = 1'b0;
        start          = 1'b0;
        clear          = 1'b0;
        spike_times_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_ready", 32'(ready), 32'd1);
        rst_n = 1'b1;

        $display("[TB] basic timing");
        apply_stimulus(1'b1, 1'b0, pack4(3, 0, 7, 5));
        repeat (12) apply_stimulus(1'b0, 1'b0, '0);

        $display("[TB] ties and sentinel");
        apply_stimulus(1'b1, 1'b0, pack4(2, 2, 8, 15));
        repeat (12) apply_stimulus(1'b0, 1'b0, '0);

        $display("[TB] back-to-back with changing inputs");
        repeat (35) apply_stimulus(1'b1, 1'b0, rand_times());
        repeat (12) apply_stimulus(1'b0, 1'b0, rand_times());

        $display("[TB] abort");
        apply_stimulus(1'b1, 1'b0, pack4(1, 5, 6, 0));
        repeat (4) apply_stimulus(1'b0, 1'b0, rand_times());
        apply_stimulus(1'b1, 1'b1, rand_times());
        apply_stimulus(1'b1, 1'b0, pack4(7, 4, 4, 9));
        repeat (12) apply_stimulus(1'b0, 1'b0, rand_times());

        $display("[TB] async reset");
        apply_stimulus(1'b1, 1'b0, pack4(0, 1, 2, 3));
        repeat (3) apply_stimulus(1'b0, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        q.delete();
        remaining = 0;
        #1;
        check_output("arst_busy", 32'(busy), 32'd0);
        check_output("arst_time_val", 32'(time_val), 32'd0);
        check_output("arst_volley", 32'(spike_volley), 32'd0);
        check_output("arst_cycle_start", 32'(cycle_start), 32'd0);
        check_output("arst_cycle_done", 32'(cycle_done), 32'd0);
        check_output("arst_ready", 32'(ready), 32'd1);
        repeat (2) apply_stimulus(1'b0, 1'b0, '0);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b0, pack4(6, 6, 0, 12));
        repeat (12) apply_stimulus(1'b0, 1'b0, '0);

        $display("[TB] random traffic");
        for (int k = 0; k < 200; k++) begin
            apply_stimulus($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, rand_times());
        end
        repeat (12) apply_stimulus(1'b0, 1'b0, '0);

        check_output("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
